reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter WID, default 32, data width.
REQ-002 SHALL have parameter DEPTH, default 8, slot count; power of two, at least 2.
REQ-003 SHALL have parameter AWID, default $clog2(DEPTH), slot index width; tags are AWID+1 bits (MSB = wrap bit).
REQ-004 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port softreset, input, 1, synchronous clear.
REQ-007 SHALL have ports alloc_req (input, 1), alloc_gnt (output, 1), alloc_tag (output, AWID+1): tag issue.
REQ-008 SHALL have ports cmpl_vld (input, 1), cmpl_tag (input, AWID+1), cmpl_data (input, WID): out-of-order completion.
REQ-009 SHALL have ports dout_vld (output, 1), dout_rdy (input, 1), dout (output, WID): in-order retire.
REQ-010 SHALL have ports full (output, 1), empty (output, 1), count (output, 16, zero-extended occupancy).
REQ-011 SHALL have ports err_unalloc (output, 1) and err_dup (output, 1), one-cycle error pulses.

Function
REQ-012 SHALL keep tail and head pointers of AWID+1 bits, each wrapping 2*DEPTH-1 -> 0; occupancy = tail - head modulo 2*DEPTH.
REQ-013 SHALL drive full = (occupancy == DEPTH) and empty = (occupancy == 0), both from registered pointers.
REQ-014 SHALL drive alloc_tag = tail and alloc_gnt = alloc_req && !full, combinationally.
REQ-015 SHALL, on alloc_gnt, increment tail and mark slot tail[AWID-1:0] outstanding, done bit cleared.
REQ-016 SHALL evaluate gnt against full before same-cycle retire; no alloc bypass when full.
REQ-017 SHALL accept a completion only if (cmpl_tag - head) mod 2*DEPTH < occupancy and slot not done; then write cmpl_data to slot cmpl_tag[AWID-1:0] and set done.
REQ-018 SHALL, for cmpl_vld with tag outside the outstanding window, ignore it and pulse err_unalloc the next cycle.
REQ-019 SHALL, for cmpl_vld to an in-window slot already done, ignore it (data unchanged) and pulse err_dup the next cycle.
REQ-020 SHALL treat completion of a tag allocated in the same cycle as unallocated (REQ-018).
REQ-021 SHALL drive dout_vld = !empty && done[head slot] and dout = slot data at head, combinationally from registered state.
REQ-022 SHALL, on dout_vld && dout_rdy, clear head slot state and increment head.
REQ-023 SHALL give latency one cycle from accepted completion of the head tag to dout_vld high.
REQ-024 SHALL hold dout and dout_vld stable while dout_vld && !dout_rdy.
REQ-025 SHALL leave count unchanged on simultaneous grant and retire; +1 on grant only; -1 on retire only.
REQ-026 SHALL allow grant, completion and retire in one cycle, each on its own slot.
REQ-027 SHALL give softreset priority over all same-cycle grant, completion and retire; head, tail, slot states and error flags go to 0; data array not cleared.

Reset
REQ-028 SHALL, while rst_n low, force head=0, tail=0, all slot states cleared, err_unalloc=0, err_dup=0.
REQ-029 SHALL, after reset, output alloc_gnt=alloc_req, alloc_tag=0, dout_vld=0, full=0, empty=1, count=0.
REQ-030 SHALL not reset the data array; dout content is don't-care while dout_vld=0.

Verification
REQ-031 DEPTH=8: grant 4 tags (0..3), complete 3,1,2,0 with data A3,A1,A2,A0, dout_rdy=1 -> dout_vld rises one cycle after tag 0 completes; A0,A1,A2,A3 retire on consecutive cycles; count returns to 0.
REQ-032 Grant 8 tags -> full=1, count=8, alloc_gnt=0 with alloc_req=1; complete tag 0 and retire it while requesting -> gnt still 0 that cycle, alloc_tag=8 granted next cycle.
REQ-033 Run 40 grant/complete/retire transactions, occupancy 1..8 -> tags wrap 15->0, data in order, no error pulses.
REQ-034 Complete tag 5 with only 0..3 outstanding -> err_unalloc one cycle, state unchanged; complete tag 2 twice -> err_dup on second, first data retained.
REQ-035 Outstanding 0..5, some done, assert softreset with simultaneous alloc_req, cmpl_vld, dout_rdy -> next cycle count=0, empty=1, dout_vld=0, alloc_tag=0, no error pulse.
REQ-036 Assert rst_n low mid-burst, asynchronously between edges -> outputs take REQ-029 values immediately, without a clock edge.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: issues tags in order, accepts completions out of order and
// retires completed entries strictly in allocation order.
module reorder_buffer #(
    parameter int WID   = 32,
    parameter int DEPTH = 8,
    parameter int AWID  = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            softreset,
    input  logic            alloc_req,
    output logic            alloc_gnt,
    output logic [AWID:0]   alloc_tag,
    input  logic            cmpl_vld,
    input  logic [AWID:0]   cmpl_tag,
    input  logic [WID-1:0]  cmpl_data,
    output logic            dout_vld,
    input  logic            dout_rdy,
    output logic [WID-1:0]  dout,
    output logic            full,
    output logic            empty,
    output logic [15:0]     count,
    output logic            err_unalloc,
    output logic            err_dup
);

    // Tags carry one extra wrap bit so that full and empty are distinguishable.
    localparam logic [AWID:0] L_DEPTH = (AWID+1)'(DEPTH);
    localparam logic [AWID:0] L_ONE   = {{AWID{1'b0}}, 1'b1};

    logic [AWID:0]    r_head;
    logic [AWID:0]    r_tail;
    logic [DEPTH-1:0] r_done;
    logic [WID-1:0]   r_data [DEPTH];
    logic             r_err_unalloc;
    logic             r_err_dup;

    logic [AWID:0]    w_occ;
    logic             w_full;
    logic             w_empty;
    logic             w_gnt;
    logic [AWID-1:0]  w_head_slot;
    logic [AWID-1:0]  w_tail_slot;
    logic [AWID-1:0]  w_cmpl_slot;
    logic [AWID:0]    w_cmpl_off;
    logic             w_cmpl_inwin;
    logic             w_cmpl_slot_done;
    logic             w_cmpl_acc;
    logic             w_cmpl_dup;
    logic             w_cmpl_unalloc;
    logic             w_vld;
    logic             w_retire;
    logic [DEPTH-1:0] w_done_nxt;

    // Occupancy and status are derived only from registered pointers, so a
    // grant is judged against the pre-retire fullness of this cycle.
    assign w_occ       = r_tail - r_head;
    assign w_full      = (w_occ == L_DEPTH);
    assign w_empty     = (w_occ == '0);
    assign w_gnt       = alloc_req && !w_full;
    assign w_head_slot = r_head[AWID-1:0];
    assign w_tail_slot = r_tail[AWID-1:0];

    // A completion is in the window when its distance from head is below the
    // registered occupancy; a tag granted this very cycle is therefore outside.
    assign w_cmpl_slot      = cmpl_tag[AWID-1:0];
    assign w_cmpl_off       = cmpl_tag - r_head;
    assign w_cmpl_inwin     = (w_cmpl_off < w_occ);
    assign w_cmpl_slot_done = r_done[w_cmpl_slot];
    assign w_cmpl_acc       = cmpl_vld &&  w_cmpl_inwin && !w_cmpl_slot_done;
    assign w_cmpl_dup       = cmpl_vld &&  w_cmpl_inwin &&  w_cmpl_slot_done;
    assign w_cmpl_unalloc   = cmpl_vld && !w_cmpl_inwin;

    assign w_vld    = !w_empty && r_done[w_head_slot];
    assign w_retire = w_vld && dout_rdy;

    assign alloc_gnt   = w_gnt;
    assign alloc_tag   = r_tail;
    assign dout_vld    = w_vld;
    assign dout        = r_data[w_head_slot];
    assign full        = w_full;
    assign empty       = w_empty;
    assign count       = 16'(w_occ);
    assign err_unalloc = r_err_unalloc;
    assign err_dup     = r_err_dup;

    // Next done-bit vector: grant, completion and retire each touch a distinct slot.
    always_comb begin
        w_done_nxt = r_done;
        if (w_retire) begin
            w_done_nxt[w_head_slot] = 1'b0;
        end
        if (w_gnt) begin
            w_done_nxt[w_tail_slot] = 1'b0;
        end
        if (w_cmpl_acc) begin
            w_done_nxt[w_cmpl_slot] = 1'b1;
        end
    end

    // Control state: pointers, done bits and error pulses; softreset overrides all.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_done        <= '0;
            r_err_unalloc <= 1'b0;
            r_err_dup     <= 1'b0;
        end else if (softreset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_done        <= '0;
            r_err_unalloc <= 1'b0;
            r_err_dup     <= 1'b0;
        end else begin
            if (w_gnt) begin
                r_tail <= r_tail + L_ONE;
            end
            if (w_retire) begin
                r_head <= r_head + L_ONE;
            end
            r_done        <= w_done_nxt;
            r_err_unalloc <= w_cmpl_unalloc;
            r_err_dup     <= w_cmpl_dup;
        end
    end

    // Payload storage is never reset; content is only meaningful once done is set.
    always_ff @(posedge clk) begin
        if (w_cmpl_acc && !softreset) begin
            r_data[w_cmpl_slot] <= cmpl_data;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic, all
// checked each cycle against a queue-based model of allocation order.
module tb_reorder_buffer;

    localparam int WID   = 32;
    localparam int DEPTH = 8;
    localparam int AWID  = 3;
    localparam int NTAG  = 2 * DEPTH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            softreset = 1'b0;
    logic            alloc_req = 1'b0;
    logic            alloc_gnt;
    logic [AWID:0]   alloc_tag;
    logic            cmpl_vld = 1'b0;
    logic [AWID:0]   cmpl_tag = '0;
    logic [WID-1:0]  cmpl_data = '0;
    logic            dout_vld;
    logic            dout_rdy = 1'b0;
    logic [WID-1:0]  dout;
    logic            full;
    logic            empty;
    logic [15:0]     count;
    logic            err_unalloc;
    logic            err_dup;

    reorder_buffer #(.WID(WID), .DEPTH(DEPTH), .AWID(AWID)) dut (
        .clk(clk), .rst_n(rst_n), .softreset(softreset),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .cmpl_vld(cmpl_vld), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
        .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout(dout),
        .full(full), .empty(empty), .count(count),
        .err_unalloc(err_unalloc), .err_dup(err_dup)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;
    bit   m_eu = 0;
    bit   m_ed = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic        s_gnt, s_vld, s_full, s_empty, s_eu, s_ed;
    logic [3:0]  s_tag;
    logic [31:0] s_dout;
    logic [15:0] s_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        q.delete();
        m_tail = 0;
        m_eu = 0;
        m_ed = 0;
    endfunction

    function automatic int find_tag(input int tag);
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].tag == tag) return i;
        end
        return -1;
    endfunction

    // Compare every DUT output with what the model says for the current inputs.
    task automatic check_model(input bit req);
        bit e_full, e_vld;
        e_full = (q.size() == DEPTH);
        e_vld  = (q.size() > 0) && q[0].done;
        chk("full", full, e_full);
        chk("empty", empty, q.size() == 0);
        chk("count", count, q.size());
        chk("alloc_tag", alloc_tag, m_tail);
        chk("alloc_gnt", alloc_gnt, req && !e_full);
        chk("dout_vld", dout_vld, e_vld);
        if (e_vld) chk("dout", dout, q[0].data);
        chk("err_unalloc", err_unalloc, m_eu);
        chk("err_dup", err_dup, m_ed);
        s_gnt = alloc_gnt; s_tag = alloc_tag; s_vld = dout_vld; s_dout = dout;
        s_full = full; s_empty = empty; s_count = count; s_eu = err_unalloc; s_ed = err_dup;
    endtask

    // Advance the model by one clock edge using the rules of the buffer.
    task automatic model_update(input bit req, input bit cv, input int ctag,
                                input logic [31:0] cdata, input bit rdy, input bit srst);
        bit ret, gnt;
        int idx;
        if (!rst_n || srst) begin
            model_clear();
            return;
        end
        gnt = req && (q.size() < DEPTH);
        ret = (q.size() > 0) && q[0].done && rdy;
        m_eu = 0;
        m_ed = 0;
        if (cv) begin
            idx = find_tag(ctag);
            if (idx < 0) m_eu = 1;
            else if (q[idx].done) m_ed = 1;
            else begin
                q[idx].done = 1;
                q[idx].data = cdata;
            end
        end
        if (ret) void'(q.pop_front());
        if (gnt) begin
            q.push_back('{tag: m_tail, done: 1'b0, data: 32'h0});
            m_tail = (m_tail + 1) % NTAG;
        end
    endtask

    task automatic step(input bit req, input bit cv, input int ctag,
                        input logic [31:0] cdata, input bit rdy, input bit srst);
        alloc_req = req;
        cmpl_vld  = cv;
        cmpl_tag  = ctag[AWID:0];
        cmpl_data = cdata;
        dout_rdy  = rdy;
        softreset = srst;
        #1;
        check_model(req);
        @(posedge clk);
        model_update(req, cv, ctag, cdata, rdy, srst);
        @(negedge clk);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 0, 32'h0, rdy, 1'b0);
    endtask

    // Complete outstanding entries head-first and retire until the buffer is empty.
    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 200) begin
            int idx;
            idx = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (!q[i].done && idx < 0) idx = i;
            end
            if (idx >= 0) step(1'b0, 1'b1, q[idx].tag, $urandom, 1'b1, 1'b0);
            else idle(1'b1);
            k++;
        end
        idle(1'b1);
        chk("drain_count", s_count, 16'd0);
    endtask

    task automatic random_phase(input int cycles, input bit inject);
        for (int c = 0; c < cycles; c++) begin
            bit req, cv, rdy, srst;
            int ctag, nd;
            int pend[$];
            pend.delete();
            for (int i = 0; i < q.size(); i++) if (!q[i].done) pend.push_back(q[i].tag);
            req  = ($urandom_range(0, 3) != 0);
            rdy  = ($urandom_range(0, 3) != 0);
            cv   = 1'b0;
            ctag = 0;
            srst = inject && ($urandom_range(0, 63) == 0);
            nd   = pend.size();
            if (inject && $urandom_range(0, 5) == 0) begin
                cv = 1'b1;
                ctag = $urandom_range(0, NTAG - 1);
            end else if (nd > 0 && $urandom_range(0, 3) != 0) begin
                cv = 1'b1;
                ctag = pend[$urandom_range(0, nd - 1)];
            end
            step(req, cv, ctag, $urandom, rdy, srst);
        end
    endtask

    initial begin
        int t0;
        logic [31:0] a [4];
        logic [31:0] d1;

        // Reset state while rst_n is held low, then after release.
        @(negedge clk);
        idle(1'b0);
        chk("rst_empty", s_empty, 1'b1);
        chk("rst_count", s_count, 16'd0);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        chk("rst_tag", s_tag, 4'd0);
        chk("rst_gnt", s_gnt, 1'b1);
        chk("rst_vld", s_vld, 1'b0);
        drain();

        // Four grants, completions 3,1,2,0, in-order retire.
        t0 = m_tail;
        for (int i = 0; i < 4; i++) a[i] = 32'hA000_0000 + i;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, (t0 + 3) % NTAG, a[3], 1'b1, 1'b0);
        step(1'b0, 1'b1, (t0 + 1) % NTAG, a[1], 1'b1, 1'b0);
        step(1'b0, 1'b1, (t0 + 2) % NTAG, a[2], 1'b1, 1'b0);
        step(1'b0, 1'b1, t0, a[0], 1'b1, 1'b0);
        chk("ooo_vld_before", s_vld, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1'b1);
            chk("ooo_vld", s_vld, 1'b1);
            chk("ooo_dout", s_dout, 32'hA000_0000 + i);
        end
        idle(1'b1);
        chk("ooo_count0", s_count, 16'd0);

        // Fill to full, then retire while requesting: no same-cycle bypass.
        t0 = m_tail;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, t0, 32'h5555_0000, 1'b0, 1'b0);
        chk("full_flag", s_full, 1'b1);
        chk("full_count", s_count, 16'd8);
        chk("full_gnt", s_gnt, 1'b0);
        step(1'b1, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        chk("full_retire_gnt", s_gnt, 1'b0);
        chk("full_retire_vld", s_vld, 1'b1);
        step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        chk("full_next_gnt", s_gnt, 1'b1);
        chk("full_next_tag", s_tag, (t0 + 8) % NTAG);
        drain();

        // Unallocated and duplicate completions.
        t0 = m_tail;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, (t0 + 5) % NTAG, 32'hDEAD_BEEF, 1'b0, 1'b0);
        idle(1'b0);
        chk("unalloc_pulse", s_eu, 1'b1);
        chk("unalloc_count", s_count, 16'd4);
        d1 = 32'h1234_5678;
        step(1'b0, 1'b1, (t0 + 2) % NTAG, d1, 1'b0, 1'b0);
        chk("unalloc_one_cycle", s_eu, 1'b0);
        step(1'b0, 1'b1, (t0 + 2) % NTAG, 32'h8765_4321, 1'b0, 1'b0);
        chk("dup_first_clean", s_ed, 1'b0);
        idle(1'b0);
        chk("dup_pulse", s_ed, 1'b1);
        step(1'b0, 1'b1, t0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, (t0 + 1) % NTAG, 32'h0, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("dup_kept_data", s_dout, d1);
        drain();

        // Softreset wins over simultaneous grant, completion and retire.
        t0 = m_tail;
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, t0, 32'hC0, 1'b0, 1'b0);
        step(1'b0, 1'b1, (t0 + 2) % NTAG, 32'hC2, 1'b0, 1'b0);
        step(1'b1, 1'b1, (t0 + 7) % NTAG, 32'hC7, 1'b1, 1'b1);
        idle(1'b0);
        chk("srst_count", s_count, 16'd0);
        chk("srst_empty", s_empty, 1'b1);
        chk("srst_vld", s_vld, 1'b0);
        chk("srst_tag", s_tag, 4'd0);
        chk("srst_eu", s_eu, 1'b0);

        // Clean random traffic: wraps tags many times with no error pulses.
        random_phase(1500, 1'b0);
        drain();

        // Asynchronous reset between edges mid-burst.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, q[0].tag, 32'hFACE, 1'b0, 1'b0);
        alloc_req = 1'b1; cmpl_vld = 1'b0; dout_rdy = 1'b0; softreset = 1'b0;
        #1;
        chk("pre_areset_vld", dout_vld, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_model(1'b1);
        chk("areset_vld", s_vld, 1'b0);
        chk("areset_count", s_count, 16'd0);
        chk("areset_tag", s_tag, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with bad tags, duplicates and occasional softreset.
        random_phase(800, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
